// File: rtl/exc_if.sv
// Bundle between the pipeline and the exception controller.
// master = pipeline side, slave = exc_ctrl side.
interface exc_if;
   logic        alu_ov;
   logic        ov_valid;
   logic [31:0] pc_alu;
   logic [31:0] pc_next;
   logic [5:0]  int_req;
   logic        eret;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic        ov_kill;
   logic        exc_flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        in_handler;

   modport master (
      output alu_ov, ov_valid, pc_alu, pc_next, int_req, eret, cp0_we, cp0_addr, cp0_wdata,
      input  cp0_rdata, ov_kill, exc_flush, redirect, redirect_pc, in_handler
   );

   modport slave (
      input  alu_ov, ov_valid, pc_alu, pc_next, int_req, eret, cp0_we, cp0_addr, cp0_wdata,
      output cp0_rdata, ov_kill, exc_flush, redirect, redirect_pc, in_handler
   );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller with CP0 Status/Cause/EPC.
// Overflow trapping is built only when OV_TRAP_EN is defined.
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0008,
   parameter logic [4:0]  EXC_OV     = 5'd12,
   parameter logic [4:0]  EXC_INT    = 5'd0
) (
   input  logic  clk,
   input  logic  reset,
   exc_if.slave  io_exc
);

   typedef enum logic [2:0] {StRun, StFlush, StRedirect, StHandler, StReturn} state_e;

   state_e      r_state;
   logic [5:0]  r_im;
   logic [5:0]  r_ip;
   logic        r_exl;
   logic        r_ie;
   logic        r_ovl;
   logic [4:0]  r_exc_code;
   logic [31:0] r_epc;
   logic        r_exc_flush;
   logic        r_redirect;
   logic [31:0] r_redirect_pc;

   logic        w_ov_hit;
   logic        w_run;
   logic        w_ov_trap;
   logic        w_int_trap;
   logic        w_wr_status;
   logic        w_wr_cause;
   logic        w_wr_epc;
   logic [31:0] w_epc_mtc;

`ifdef OV_TRAP_EN
   assign w_ov_hit = io_exc.ov_valid & io_exc.alu_ov;
`else
   logic w_unused_ov;
   assign w_ov_hit    = 1'b0;
   assign w_unused_ov = io_exc.ov_valid ^ io_exc.alu_ov;
`endif

   // reset gating keeps ov_kill low while held in reset
   assign w_run      = (r_state == StRun) & reset;
   assign w_ov_trap  = w_ov_hit & w_run & ~r_exl;
   assign w_int_trap = r_ie & ~r_exl & (|(io_exc.int_req & r_im)) & w_run;

   assign w_wr_status = io_exc.cp0_we & (io_exc.cp0_addr == 5'd12);
   assign w_wr_cause  = io_exc.cp0_we & (io_exc.cp0_addr == 5'd13);
   assign w_wr_epc    = io_exc.cp0_we & (io_exc.cp0_addr == 5'd14);
   assign w_epc_mtc   = w_wr_epc ? io_exc.cp0_wdata : r_epc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= StRun;
         r_im          <= '0;
         r_ip          <= '0;
         r_exl         <= 1'b0;
         r_ie          <= 1'b0;
         r_ovl         <= 1'b0;
         r_exc_code    <= '0;
         r_epc         <= '0;
         r_exc_flush   <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
      end else begin
         r_exc_flush <= 1'b0;
         r_redirect  <= 1'b0;
         r_ip        <= io_exc.int_req;
         r_epc       <= w_epc_mtc;
         if (w_wr_status) begin
            r_im  <= io_exc.cp0_wdata[15:10];
            r_exl <= io_exc.cp0_wdata[1];
            r_ie  <= io_exc.cp0_wdata[0];
         end
         if (w_wr_cause) begin
            r_ovl <= io_exc.cp0_wdata[30];
         end
         // later assignments below take priority over the MTC0 writes above
         case (r_state)
            StRun: begin
               if (w_ov_trap) begin
                  r_epc       <= io_exc.pc_alu;
                  r_exc_code  <= EXC_OV;
                  r_exl       <= 1'b1;
                  r_exc_flush <= 1'b1;
                  r_state     <= StFlush;
               end else if (w_int_trap) begin
                  r_epc       <= io_exc.pc_next;
                  r_exc_code  <= EXC_INT;
                  r_exl       <= 1'b1;
                  r_exc_flush <= 1'b1;
                  r_state     <= StFlush;
               end
            end
            StFlush: begin
               r_redirect    <= 1'b1;
               r_redirect_pc <= EXC_VECTOR;
               r_state       <= StRedirect;
            end
            StRedirect: begin
               r_state <= StHandler;
            end
            StHandler: begin
               if (w_ov_hit) begin
                  r_ovl <= 1'b1;
               end
               if (io_exc.eret) begin
                  r_exl         <= 1'b0;
                  r_redirect    <= 1'b1;
                  r_redirect_pc <= w_epc_mtc;
                  r_state       <= StReturn;
               end
            end
            StReturn: begin
               r_state <= StRun;
            end
            default: begin
               r_state <= StRun;
            end
         endcase
      end
   end

   always_comb begin
      io_exc.cp0_rdata = 32'h0;
      case (io_exc.cp0_addr)
         5'd12:   io_exc.cp0_rdata = {16'h0, r_im, 8'h0, r_exl, r_ie};
         5'd13:   io_exc.cp0_rdata = {1'b0, r_ovl, 14'h0, r_ip, 3'h0, r_exc_code, 2'h0};
         5'd14:   io_exc.cp0_rdata = r_epc;
         default: io_exc.cp0_rdata = 32'h0;
      endcase
   end

   assign io_exc.ov_kill     = w_ov_trap;
   assign io_exc.exc_flush   = r_exc_flush;
   assign io_exc.redirect    = r_redirect;
   assign io_exc.redirect_pc = r_redirect_pc;
   assign io_exc.in_handler  = r_exl;

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized bench for exc_ctrl with a cycle-indexed behavioural model and directed scenarios.
// Honours OV_TRAP_EN the same way as the design.
module tb_exc_ctrl;

`ifdef OV_TRAP_EN
   localparam bit OvEn = 1'b1;
`else
   localparam bit OvEn = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   exc_if u_if ();

   exc_ctrl u_dut (
      .clk    (clk),
      .reset  (reset),
      .io_exc (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (event schedule by cycle index) ----------------
   longint      m_cyc;
   longint      m_fc;     // cycle in which exc_flush must be high
   longint      m_rc;     // cycle in which redirect must be high
   bit          m_ent;    // trap taken and not yet returned
   logic [31:0] m_tgt;
   logic [31:0] m_rpc;
   logic [31:0] m_epc;
   logic [5:0]  m_im;
   logic [5:0]  m_ip;
   logic        m_exl;
   logic        m_ie;
   logic        m_ovl;
   logic [4:0]  m_code;

   task automatic model_reset();
      m_fc   = -1;
      m_rc   = -1;
      m_ent  = 1'b0;
      m_tgt  = '0;
      m_rpc  = '0;
      m_epc  = '0;
      m_im   = '0;
      m_ip   = '0;
      m_exl  = 1'b0;
      m_ie   = 1'b0;
      m_ovl  = 1'b0;
      m_code = '0;
   endtask

   function automatic logic [31:0] exp_rdata(input logic [4:0] a);
      if (a == 5'd12) return {16'h0, m_im, 8'h0, m_exl, m_ie};
      if (a == 5'd13) return {1'b0, m_ovl, 14'h0, m_ip, 3'h0, m_code, 2'h0};
      if (a == 5'd14) return m_epc;
      return 32'h0;
   endfunction

   initial begin
      m_cyc = 0;
      model_reset();
   end

   always @(negedge clk) begin
      bit          run, hdl, ovhit, ovt, intt;
      logic [31:0] n_epc;
      if (!reset) model_reset();
      run   = reset && !m_ent && (m_cyc > m_rc);
      hdl   = reset && m_ent && (m_cyc > m_rc);
      ovhit = OvEn && u_if.ov_valid && u_if.alu_ov;
      ovt   = ovhit && run && !m_exl;
      intt  = m_ie && !m_exl && ((u_if.int_req & m_im) != 0) && run;

      chk("ov_kill",     {31'h0, u_if.ov_kill},    {31'h0, ovt});
      chk("exc_flush",   {31'h0, u_if.exc_flush},  {31'h0, m_cyc == m_fc});
      chk("redirect",    {31'h0, u_if.redirect},   {31'h0, m_cyc == m_rc});
      chk("redirect_pc", u_if.redirect_pc,         m_rpc);
      chk("in_handler",  {31'h0, u_if.in_handler}, {31'h0, m_exl});
      chk("cp0_rdata",   u_if.cp0_rdata,           exp_rdata(u_if.cp0_addr));

      if (reset) begin
         n_epc = (u_if.cp0_we && u_if.cp0_addr == 5'd14) ? u_if.cp0_wdata : m_epc;
         if (u_if.cp0_we && u_if.cp0_addr == 5'd12) begin
            m_im  = u_if.cp0_wdata[15:10];
            m_exl = u_if.cp0_wdata[1];
            m_ie  = u_if.cp0_wdata[0];
         end
         if (u_if.cp0_we && u_if.cp0_addr == 5'd13) m_ovl = u_if.cp0_wdata[30];
         if (hdl && ovhit) m_ovl = 1'b1;
         if (ovt || intt) begin
            n_epc  = ovt ? u_if.pc_alu : u_if.pc_next;
            m_code = ovt ? 5'd12 : 5'd0;
            m_exl  = 1'b1;
            m_ent  = 1'b1;
            m_fc   = m_cyc + 1;
            m_rc   = m_cyc + 2;
            m_tgt  = 32'h8;
         end
         if (hdl && u_if.eret) begin
            m_exl = 1'b0;
            m_ent = 1'b0;
            m_rc  = m_cyc + 1;
            m_tgt = n_epc;
         end
         m_epc = n_epc;
         m_ip  = u_if.int_req;
      end
      m_cyc++;
      if (m_cyc == m_rc) m_rpc = m_tgt;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      u_if.alu_ov    = 1'b0;
      u_if.ov_valid  = 1'b0;
      u_if.pc_alu    = '0;
      u_if.pc_next   = '0;
      u_if.int_req   = '0;
      u_if.eret      = 1'b0;
      u_if.cp0_we    = 1'b0;
      u_if.cp0_addr  = '0;
      u_if.cp0_wdata = '0;
   endtask

   task automatic write_cp0(input logic [4:0] a, input logic [31:0] d);
      tick();
      u_if.cp0_we    = 1'b1;
      u_if.cp0_addr  = a;
      u_if.cp0_wdata = d;
      tick();
      u_if.cp0_we    = 1'b0;
   endtask

   initial begin
      logic [4:0] addrs [3];
      n_checks = 0;
      n_fail   = 0;
      addrs[0] = 5'd12;
      addrs[1] = 5'd13;
      addrs[2] = 5'd14;
      reset    = 1'b0;
      clear_inputs();

      // Reset state, with an overflow presented while held in reset
      repeat (2) @(posedge clk);
      #2;
      u_if.ov_valid = 1'b1;
      u_if.alu_ov   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         u_if.cp0_addr = addrs[i];
         #1 chk("rst_rdata", u_if.cp0_rdata, 32'h0);
      end
      chk("rst_kill", {31'h0, u_if.ov_kill}, 32'h0);
      chk("rst_flush", {31'h0, u_if.exc_flush}, 32'h0);
      chk("rst_redirect", {31'h0, u_if.redirect}, 32'h0);
      chk("rst_redirect_pc", u_if.redirect_pc, 32'h0);
      chk("rst_in_handler", {31'h0, u_if.in_handler}, 32'h0);
      clear_inputs();
      tick();
      reset = 1'b1;

`ifdef OV_TRAP_EN
      // Overflow trap timeline
      tick();
      u_if.ov_valid = 1'b1; u_if.alu_ov = 1'b1; u_if.pc_alu = 32'h40;
      #4 chk("ov_kill_n", {31'h0, u_if.ov_kill}, 32'h1);
      tick();
      u_if.ov_valid = 1'b0; u_if.alu_ov = 1'b0;
      #4 chk("ov_flush_n1", {31'h0, u_if.exc_flush}, 32'h1);
      tick();
      #4 chk("ov_redir_n2", {31'h0, u_if.redirect}, 32'h1);
      chk("ov_redir_pc", u_if.redirect_pc, 32'h8);
      tick();
      u_if.cp0_addr = 5'd14;
      #4 chk("ov_epc", u_if.cp0_rdata, 32'h40);
      u_if.cp0_addr = 5'd13;
      #1 chk("ov_code", {27'h0, u_if.cp0_rdata[6:2]}, 32'd12);
      chk("ov_in_handler", {31'h0, u_if.in_handler}, 32'h1);
      // Second overflow inside handler only sets OVL
      tick();
      u_if.ov_valid = 1'b1; u_if.alu_ov = 1'b1;
      #4 chk("nest_kill", {31'h0, u_if.ov_kill}, 32'h0);
      tick();
      u_if.ov_valid = 1'b0; u_if.alu_ov = 1'b0;
      #4 chk("nest_flush", {31'h0, u_if.exc_flush}, 32'h0);
      chk("nest_ovl", {31'h0, u_if.cp0_rdata[30]}, 32'h1);
      tick();
      u_if.eret = 1'b1;
      tick();
      u_if.eret = 1'b0;
      #4 chk("eret_redir", {31'h0, u_if.redirect}, 32'h1);
      chk("eret_pc", u_if.redirect_pc, 32'h40);
      chk("eret_exl", {31'h0, u_if.in_handler}, 32'h0);
      write_cp0(5'd13, 32'h0);
`else
      // Overflow trapping disabled: no kill, no flush, Cause untouched
      tick();
      u_if.ov_valid = 1'b1; u_if.alu_ov = 1'b1; u_if.pc_alu = 32'h40;
      #4 chk("noov_kill", {31'h0, u_if.ov_kill}, 32'h0);
      tick();
      u_if.ov_valid = 1'b0; u_if.alu_ov = 1'b0; u_if.cp0_addr = 5'd13;
      #4 chk("noov_flush", {31'h0, u_if.exc_flush}, 32'h0);
      chk("noov_cause", u_if.cp0_rdata, 32'h0);
`endif

      // Interrupt trap
      write_cp0(5'd12, 32'h0000_0401);
      u_if.int_req = 6'b000001; u_if.pc_next = 32'h100;
      tick();
      u_if.int_req = '0;
      #4 chk("int_flush", {31'h0, u_if.exc_flush}, 32'h1);
      tick();
      #4 chk("int_redir", {31'h0, u_if.redirect}, 32'h1);
      chk("int_redir_pc", u_if.redirect_pc, 32'h8);
      tick();
      u_if.cp0_addr = 5'd14;
      #4 chk("int_epc", u_if.cp0_rdata, 32'h100);
      u_if.cp0_addr = 5'd13;
      #1 chk("int_code", {27'h0, u_if.cp0_rdata[6:2]}, 32'd0);
      tick();
      u_if.eret = 1'b1;
      tick();
      u_if.eret = 1'b0;
      #4 chk("int_ret_pc", u_if.redirect_pc, 32'h100);
      write_cp0(5'd12, 32'h0000_0400);
      u_if.int_req = 6'b000001;
      for (int i = 0; i < 4; i++) begin
         tick();
         #4 chk("ie0_flush", {31'h0, u_if.exc_flush}, 32'h0);
      end
      u_if.int_req = '0;

`ifdef OV_TRAP_EN
      // Overflow beats a simultaneous interrupt; interrupt follows ERET
      write_cp0(5'd12, 32'h0000_0401);
      u_if.ov_valid = 1'b1; u_if.alu_ov = 1'b1; u_if.pc_alu = 32'h200;
      u_if.int_req = 6'b000001; u_if.pc_next = 32'h300;
      #4 chk("pri_kill", {31'h0, u_if.ov_kill}, 32'h1);
      tick();
      u_if.ov_valid = 1'b0; u_if.alu_ov = 1'b0;
      tick();
      tick();
      u_if.cp0_addr = 5'd14;
      #4 chk("pri_epc", u_if.cp0_rdata, 32'h200);
      u_if.cp0_addr = 5'd13;
      #1 chk("pri_code", {27'h0, u_if.cp0_rdata[6:2]}, 32'd12);
      tick();
      u_if.eret = 1'b1;
      tick();
      u_if.eret = 1'b0;
      tick();
      tick();
      #4 chk("pend_flush", {31'h0, u_if.exc_flush}, 32'h1);
      u_if.int_req = '0;
      tick();
      tick();
      u_if.cp0_addr = 5'd14;
      #4 chk("pend_epc", u_if.cp0_rdata, 32'h300);
      tick();
      u_if.eret = 1'b1;
      tick();
      u_if.eret = 1'b0;
      tick();
`endif

      // Reset during REDIRECT drops redirect at once
      write_cp0(5'd12, 32'h0000_0401);
      u_if.int_req = 6'b000001;
      tick();
      u_if.int_req = '0;
      tick();
      chk("pre_rst_redir", {31'h0, u_if.redirect}, 32'h1);
      reset = 1'b0;
      #1 chk("rst_redir_drop", {31'h0, u_if.redirect}, 32'h0);
      chk("rst_exl_drop", {31'h0, u_if.in_handler}, 32'h0);
      tick();
      tick();
      reset = 1'b1;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         if ($urandom_range(0, 399) == 0) begin
            reset = 1'b0;
            tick();
            reset = 1'b1;
         end
         u_if.ov_valid = ($urandom_range(0, 5) == 0);
         u_if.alu_ov   = 1'($urandom_range(0, 1));
         u_if.pc_alu   = $urandom & 32'hFFFF_FFFC;
         u_if.pc_next  = $urandom & 32'hFFFF_FFFC;
         u_if.int_req  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h0;
         u_if.eret     = ($urandom_range(0, 5) == 0);
         u_if.cp0_we   = ($urandom_range(0, 9) == 0);
         u_if.cp0_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 2)];
         u_if.cp0_wdata = $urandom;
         // Keep Status mostly in a trap-enabled, EXL-clear configuration
         if (u_if.cp0_addr == 5'd12 && $urandom_range(0, 3) != 0)
            u_if.cp0_wdata = (u_if.cp0_wdata & 32'h0000_FC00) | 32'h1;
      end
      clear_inputs();
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
